// File: rtl/uart_rx_framer.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// configurable data/parity/stop framing and a valid/ready holding register with overrun.
module uart_rx_framer #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [1:0]           r_hist;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_sidx;

    logic w_rx_s;
    logic w_maj;
    logic w_fall;
    logic w_tick;
    logic w_par_xor;
    logic w_par_bad;
    logic w_ferr_fin;
    logic w_last_stop;

    assign w_rx_s      = r_sync[1];
    assign w_maj       = (w_rx_s & r_hist[0]) | (w_rx_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
    assign w_fall      = r_hist[0] & ~w_rx_s;
    assign w_tick      = (r_cnt == '0);
    assign w_par_xor   = ^{r_shift, w_maj};
    // odd parity wants the XOR over data+parity to be 1, even wants 0
    assign w_par_bad   = (PARITY == 1) ? ~w_par_xor : w_par_xor;
    assign w_ferr_fin  = r_ferr | ~w_maj;
    assign w_last_stop = (STOP_BITS == 1) || r_sidx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sync     <= 2'b11;
            r_hist     <= 2'b11;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_sidx     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_hist  <= {r_hist[0], w_rx_s};
            overrun <= 1'b0;
            if (data_valid && data_ready)
                data_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_HALF;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_maj) begin
                        r_state <= S_DATA;
                        r_cnt   <= CNT_FULL;
                        r_idx   <= '0;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                        r_sidx  <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift[r_idx] <= w_maj;
                        r_cnt          <= CNT_FULL;
                        if (r_idx == IDX_LAST)
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            r_idx <= r_idx + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_perr  <= w_par_bad;
                        r_cnt   <= CNT_FULL;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_last_stop) begin
                        r_ferr <= w_ferr_fin;
                        r_sidx <= 1'b1;
                        r_cnt  <= CNT_FULL;
                    end else begin
                        // back to IDLE on the last stop centre so an abutting start bit is caught
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        if (!data_valid || data_ready) begin
                            data_out   <= r_shift;
                            parity_err <= r_perr;
                            frame_err  <= w_ferr_fin;
                            data_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Parametrised next-generation UART receiver for the PC-to-FPGA byte path feeding the XOR/BRAM storage stage.
- Generalises the fixed 8N1 receiver to configurable data width, parity and stop bits.
- Adds an input synchroniser, 3-sample majority voting, parity/framing error reporting and a valid/ready output handshake with overrun detection.
- The downstream consumer (encryption/BRAM controller) may stall without corrupting the word being delivered.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s. Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division; must be >= 8).
- DATA_BITS, 8, data bits per frame, legal 5..9, LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame, legal 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  received word; stable while data_valid=1.
- data_valid  output  1  word available; held until accepted.
- data_ready  input  1  consumer accepts the word when data_valid & data_ready.
- parity_err  output  1  qualifies data_out: parity mismatch (always 0 when PARITY=0).
- frame_err  output  1  qualifies data_out: a stop bit sampled low.
- overrun  output  1  one-cycle pulse: a completed frame was dropped because the holding register was full.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset: data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, FSM=IDLE.
  - Synchroniser flops reset to 1 so no false start is seen after reset.
  - rst asserted mid-frame abandons the frame; nothing is delivered.
- Synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s plus a 3-deep history of rx_s.
- Bit value is the majority of rx_s over the 3 cycles ending at the bit-centre tick.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s falling (1 to 0) -> START, counter = CLKS_PER_BIT/2 - 1.
  - START: at counter==0, majority=0 -> DATA with counter=CLKS_PER_BIT-1 and bit index 0. Majority=1 -> IDLE (false start; no output, no flag).
  - DATA: at each counter==0, shift the sampled bit into position index and reload the counter. After bit DATA_BITS-1 -> PARITY if PARITY!=0, else STOP.
  - PARITY: sample one bit. Odd mode expects XOR(data, parity)=1; even mode expects 0. Mismatch sets an internal perr. Then -> STOP.
  - STOP: sample STOP_BITS bits. Any low sets an internal ferr. After the last stop sample -> IDLE in the same tick, so a start bit immediately following can be detected.
- Delivery happens in the cycle after the final stop-bit centre tick:
  - Holding register empty, or being accepted that same cycle: load data_out/parity_err/frame_err; data_valid=1.
  - Holding register full and not accepted that cycle: discard the new frame, keep the old word, pulse overrun for 1 cycle.
- Handshake:
  - data_valid falls the cycle after data_valid & data_ready unless a new word loads in that same cycle; back-to-back delivery is allowed.
  - data_ready is ignored while data_valid=0.
- Frames with errors are still delivered with the flags set; the consumer decides whether to drop them.
- Break (rx held low) yields one frame with data=0 and frame_err=1. FSM then waits in IDLE for rx_s to return high before a new falling edge can start a frame.
- Single-cycle glitches on rx are filtered by the majority vote.
- busy=1 from START entry until the IDLE return.

Test Plan:
- Bench config CLK_FREQ=1600000, BAUD_RATE=100000 (16 clk/bit), 8N1, data_ready=1. Send 0xA5 -> exactly one data_valid pulse with data_out=0xA5, parity_err=0, frame_err=0, overrun=0.
- PARITY=2 (even), send 0x03 with parity bit 0 -> data 0x03, parity_err=0. Repeat with parity bit 1 -> parity_err=1, data 0x03.
- STOP_BITS=2, send 0x5A with second stop bit driven low -> data 0x5A, frame_err=1. Next frame 0x11 correct -> frame_err=0.
- data_ready=0, send 0x12 then 0x34 back-to-back:
  - data_out stays 0x12 with data_valid held.
  - overrun pulses once at the second frame end.
  - Raising data_ready yields 0x12 only.
- Glitches: 4-cycle low pulse on idle rx -> no output (false start). 1-cycle inverted glitch at a data-bit centre of 0xC3 -> data_out=0xC3.
- Assert rst for 1 cycle midway through bit 4 of 0xFF, then send 0x81 -> only 0x81 delivered, all flags 0. Outputs are 0 in the cycle after rst.
